mem_stage_ctrl: RTL and testbench

Memory-stage controller for the five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It runs LDUR/LDURB/STUR accesses against a data memory that uses a request/grant and read-valid handshake, and stalls the upstream pipeline while an access is outstanding. It presents WriteData, destination register, write enable, shift-select and shift output to MEM/WB. Non-memory instructions pass through in one cycle; a sticky error flag reports memory timeouts.

---
 rtl/mem_stage_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: runs LDUR/LDURB/STUR against a req/gnt + rvalid
// data memory, stalls upstream while an access is outstanding, and feeds
// MEM/WB with either pass-through, bubble or completed-access values.
module mem_stage_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_EXM,
    input  logic        memRead_EXM,
    input  logic        memWrite_EXM,
    input  logic        byteSel_EXM,
    input  logic [63:0] ALU_result_EXM,
    input  logic [63:0] storeData_EXM,
    input  logic        regWrite_E_EXM,
    input  logic        shiftSel_EXM,
    input  logic [4:0]  regWrite_EXM,
    input  logic [63:0] shift_output_EXM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        dmem_size,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [63:0] dmem_rdata,
    output logic        stall_MEM,
    output logic        regWrite_E_MEM,
    output logic        shiftSel_MEM,
    output logic [4:0]  regWrite_MEM,
    output logic [63:0] WriteData_MEM,
    output logic [63:0] shift_output_MEM,
    output logic        mem_err
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [63:0]   h_addr, h_wdata, h_so, h_ldata;
    logic          h_we, h_size, h_rwe, h_ss;
    logic [4:0]    h_rw;
    logic          is_mem, last_cycle;
    logic          capture, ld_capture, timeout;

    assign is_mem     = valid_EXM & (memRead_EXM | memWrite_EXM);
    // The MAX_WAIT-th REQ/WAIT cycle is the last chance to complete.
    assign last_cycle = (cnt == CW'(MAX_WAIT - 1));

    // Next-state selection; a load grant is not a completion, so a grant
    // in the final allowed cycle still times out.
    always_comb begin
        state_nx   = state;
        capture    = 1'b0;
        ld_capture = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (is_mem) begin
                    state_nx = REQ;
                    capture  = 1'b1;
                end
            end
            REQ: begin
                if (dmem_gnt && h_we) begin
                    state_nx = DONE;
                end else if (last_cycle) begin
                    state_nx = DONE;
                    timeout  = 1'b1;
                end else if (dmem_gnt) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_nx   = DONE;
                    ld_capture = 1'b1;
                end else if (last_cycle) begin
                    state_nx = DONE;
                    timeout  = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode; everything is forced to 0 while reset is asserted.
    always_comb begin
        stall_MEM        = 1'b0;
        regWrite_E_MEM   = 1'b0;
        regWrite_MEM     = '0;
        shiftSel_MEM     = 1'b0;
        shift_output_MEM = '0;
        WriteData_MEM    = '0;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        dmem_size        = 1'b0;
        dmem_addr        = '0;
        dmem_wdata       = '0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        stall_MEM = 1'b1;
                    end else begin
                        regWrite_E_MEM   = valid_EXM & regWrite_E_EXM;
                        regWrite_MEM     = regWrite_EXM;
                        shiftSel_MEM     = shiftSel_EXM;
                        shift_output_MEM = shift_output_EXM;
                        WriteData_MEM    = ALU_result_EXM;
                    end
                end
                REQ: begin
                    stall_MEM  = 1'b1;
                    dmem_req   = 1'b1;
                    dmem_we    = h_we;
                    dmem_size  = h_size;
                    dmem_addr  = h_addr;
                    dmem_wdata = h_size ? {56'b0, h_wdata[7:0]} : h_wdata;
                end
                WAIT: stall_MEM = 1'b1;
                DONE: begin
                    regWrite_E_MEM   = h_rwe;
                    regWrite_MEM     = h_rw;
                    shiftSel_MEM     = h_ss;
                    shift_output_MEM = h_so;
                    WriteData_MEM    = h_we ? h_addr : h_ldata;
                end
                default: stall_MEM = 1'b0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Holding registers, wait counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_addr  <= '0;
            h_wdata <= '0;
            h_so    <= '0;
            h_ldata <= '0;
            h_we    <= 1'b0;
            h_size  <= 1'b0;
            h_rwe   <= 1'b0;
            h_ss    <= 1'b0;
            h_rw    <= '0;
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            if (capture) begin
                h_addr  <= ALU_result_EXM;
                h_wdata <= storeData_EXM;
                h_so    <= shift_output_EXM;
                h_ldata <= '0;
                h_we    <= memWrite_EXM;
                h_size  <= byteSel_EXM;
                h_rwe   <= regWrite_E_EXM;
                h_ss    <= shiftSel_EXM;
                h_rw    <= regWrite_EXM;
                cnt     <= '0;
            end else if (state == REQ || state == WAIT) begin
                cnt <= cnt + CW'(1);
            end
            if (ld_capture) begin
                h_ldata <= h_size ? {56'b0, dmem_rdata[7:0]} : dmem_rdata;
            end
            if (timeout) begin
                h_ldata <= '0;
                mem_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: a reactive memory with chosen
// grant/response delays, and a transaction-level model of stall length,
// handshake count and the value presented in the completion cycle.
module tb_mem_stage_ctrl;

    localparam int unsigned MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_EXM, memRead_EXM, memWrite_EXM, byteSel_EXM;
    logic [63:0] ALU_result_EXM, storeData_EXM, shift_output_EXM;
    logic        regWrite_E_EXM, shiftSel_EXM;
    logic [4:0]  regWrite_EXM;
    logic        dmem_req, dmem_we, dmem_size;
    logic [63:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [63:0] dmem_rdata;
    logic        stall_MEM, regWrite_E_MEM, shiftSel_MEM;
    logic [4:0]  regWrite_MEM;
    logic [63:0] WriteData_MEM, shift_output_MEM;
    logic        mem_err;

    mem_stage_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .valid_EXM(valid_EXM), .memRead_EXM(memRead_EXM), .memWrite_EXM(memWrite_EXM),
        .byteSel_EXM(byteSel_EXM), .ALU_result_EXM(ALU_result_EXM),
        .storeData_EXM(storeData_EXM), .regWrite_E_EXM(regWrite_E_EXM),
        .shiftSel_EXM(shiftSel_EXM), .regWrite_EXM(regWrite_EXM),
        .shift_output_EXM(shift_output_EXM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_size(dmem_size),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .stall_MEM(stall_MEM), .regWrite_E_MEM(regWrite_E_MEM),
        .shiftSel_MEM(shiftSel_MEM), .regWrite_MEM(regWrite_MEM),
        .WriteData_MEM(WriteData_MEM), .shift_output_MEM(shift_output_MEM),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        err_exp  = 1'b0;

    task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [191:0] mem_wb_outs();
        return 192'({regWrite_E_MEM, regWrite_MEM, shiftSel_MEM, shift_output_MEM, WriteData_MEM});
    endfunction

    task automatic set_instr(input logic v, input logic rd, input logic wr, input logic bs,
                             input logic [63:0] alu, input logic rwe, input logic [4:0] rw);
        valid_EXM        = v;
        memRead_EXM      = rd;
        memWrite_EXM     = wr;
        byteSel_EXM      = bs;
        ALU_result_EXM   = alu;
        storeData_EXM    = {$urandom, $urandom};
        regWrite_E_EXM   = rwe;
        regWrite_EXM     = rw;
        shiftSel_EXM     = 1'($urandom_range(0, 1));
        shift_output_EXM = {$urandom, $urandom};
    endtask

    // Runs the instruction currently on the EXM inputs to completion.
    // Called just after a rising edge; returns just after a rising edge.
    // gd: REQ cycles the memory withholds grant; rdl: WAIT cycles before rvalid.
    task automatic run_instr(input int unsigned gd, input int unsigned rdl, input logic [63:0] resp);
        logic          is_st, tmo, waiting, exp_req;
        int unsigned   total, n_stall, req_seen, wait_seen, accepted, exp_acc;
        logic [63:0]   exp_wd, exp_wdata;
        logic [191:0]  exp_done, exp_dm;
        if (!(valid_EXM && (memRead_EXM || memWrite_EXM))) begin
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata  = {$urandom, $urandom};
            @(negedge clk);
            check_eq("pass_stall", 192'(stall_MEM), 192'(0));
            check_eq("pass_out", mem_wb_outs(),
                     192'({valid_EXM & regWrite_E_EXM, regWrite_EXM, shiftSel_EXM,
                           shift_output_EXM, ALU_result_EXM}));
            check_eq("pass_req", 192'(dmem_req), 192'(0));
            check_eq("pass_err", 192'(mem_err), 192'(err_exp));
            @(posedge clk); #1;
            return;
        end
        is_st   = memWrite_EXM;
        total   = gd + 1 + (is_st ? 0 : rdl + 1);
        tmo     = (total > MAX_WAIT);
        n_stall = 1 + (tmo ? MAX_WAIT : total);
        exp_acc = (gd + 1 <= MAX_WAIT) ? 1 : 0;
        if (is_st)    exp_wd = ALU_result_EXM;
        else if (tmo) exp_wd = 64'd0;
        else          exp_wd = byteSel_EXM ? {56'd0, resp[7:0]} : resp;
        exp_wdata = !is_st ? 64'd0 : (byteSel_EXM ? {56'd0, storeData_EXM[7:0]} : storeData_EXM);
        exp_dm    = 192'({ALU_result_EXM, is_st, byteSel_EXM, exp_wdata});
        exp_done  = 192'({regWrite_E_EXM, regWrite_EXM, shiftSel_EXM, shift_output_EXM, exp_wd});
        if (tmo) err_exp = 1'b1;
        req_seen = 0; wait_seen = 0; accepted = 0; waiting = 1'b0;
        for (int unsigned c = 0; c <= n_stall; c++) begin
            dmem_gnt = dmem_req && (req_seen >= gd);
            if (waiting) begin
                dmem_rvalid = (wait_seen >= rdl);
                dmem_rdata  = resp;
            end else begin
                dmem_rvalid = 1'($urandom_range(0, 1));
                dmem_rdata  = {$urandom, $urandom};
            end
            @(negedge clk);
            if (c < n_stall) begin
                exp_req = (c >= 1) && (c <= gd + 1) && (c <= MAX_WAIT);
                check_eq("stall", 192'(stall_MEM), 192'(1));
                check_eq("bubble", mem_wb_outs(), 192'(0));
                check_eq("req", 192'(dmem_req), 192'(exp_req));
                if (dmem_req)
                    check_eq("dmem_fields",
                             192'({dmem_addr, dmem_we, dmem_size, is_st ? dmem_wdata : 64'd0}), exp_dm);
            end else begin
                check_eq("done_stall", 192'(stall_MEM), 192'(0));
                check_eq("done_out", mem_wb_outs(), exp_done);
                check_eq("done_err", 192'(mem_err), 192'(err_exp));
                check_eq("handshakes", 192'(accepted), 192'(exp_acc));
            end
            if (waiting) begin
                if (dmem_rvalid) waiting = 1'b0;
                else             wait_seen++;
            end
            if (dmem_req) begin
                if (dmem_gnt) begin
                    accepted++;
                    if (!is_st) waiting = 1'b1;
                end
                req_seen++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int unsigned kind, gd, rdl;
        reset       = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        set_instr(1'b1, 1'b1, 1'b0, 1'b0, 64'h1234, 1'b1, 5'd9);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_outs", mem_wb_outs(), 192'(0));
        check_eq("rst_stall", 192'(stall_MEM), 192'(0));
        check_eq("rst_req", 192'(dmem_req), 192'(0));
        check_eq("rst_err", 192'(mem_err), 192'(0));
        @(negedge clk);
        reset = 1'b1;
        set_instr(1'b1, 1'b0, 1'b0, 1'b0, 64'h5, 1'b1, 5'd3);
        @(posedge clk); #1;

        // Directed cases.
        run_instr(0, 0, 64'd0);                                   // ADD
        set_instr(1'b1, 1'b1, 1'b0, 1'b0, 64'h40, 1'b1, 5'd7);    // LDUR
        run_instr(0, 0, 64'hDEAD_BEEF_0123_4567);
        set_instr(1'b1, 1'b1, 1'b0, 1'b1, 64'h41, 1'b1, 5'd8);    // LDURB
        run_instr(1, 2, 64'hFFFF_FFFF_FFFF_FFA5);
        set_instr(1'b1, 1'b0, 1'b1, 1'b0, 64'h80, 1'b0, 5'd0);    // STUR, late grant
        run_instr(3, 0, 64'd0);
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 64'h81, 1'b0, 5'd0);    // STURB
        run_instr(14, 0, 64'd0);
        set_instr(1'b1, 1'b1, 1'b0, 1'b0, 64'h48, 1'b1, 5'd4);    // load, no rvalid
        run_instr(0, 100, 64'h55);
        set_instr(1'b1, 1'b0, 1'b0, 1'b0, 64'h77, 1'b1, 5'd2);    // ADD after timeout
        run_instr(0, 0, 64'd0);
        set_instr(1'b0, 1'b1, 1'b0, 1'b0, 64'h99, 1'b1, 5'd1);    // bubble with stale memRead
        run_instr(0, 0, 64'd0);

        // Randomized mix.
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 4);
            gd   = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 17) : $urandom_range(0, 3);
            rdl  = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 100) : $urandom_range(0, 3);
            set_instr(kind != 1, kind == 1 || kind == 2 || kind == 4, kind == 3 || kind == 4,
                      1'($urandom_range(0, 1)), {$urandom, $urandom},
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            run_instr(gd, rdl, {$urandom, $urandom});
        end

        // Reset during WAIT.
        set_instr(1'b1, 1'b1, 1'b0, 1'b0, 64'h60, 1'b1, 5'd5);
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        @(posedge clk); #1;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(posedge clk); #1;
        check_eq("wait_state", 192'({stall_MEM, dmem_req}), 192'(2'b10));
        #2 reset = 1'b0;
        #1;
        err_exp = 1'b0;
        check_eq("midrst_req", 192'(dmem_req), 192'(0));
        check_eq("midrst_stall", 192'(stall_MEM), 192'(0));
        check_eq("midrst_outs", mem_wb_outs(), 192'(0));
        check_eq("midrst_err", 192'(mem_err), 192'(0));
        set_instr(1'b1, 1'b0, 1'b0, 1'b0, 64'h5, 1'b1, 5'd3);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run_instr(0, 0, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
